// File: rtl/full_adder.sv
// Single-bit registered full adder: combinational sum/carry followed by a
// LATENCY-deep shift pipeline carrying {valid, carry, sum}.
module full_adder #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic in_valid,
  output logic out_valid
);

  typedef struct packed {
    logic valid;
    logic cout;
    logic s;
  } stage_t;

  // Only 1..4 register stages are supported.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("full_adder: LATENCY must be in 1..4");
  end

  logic   sum_c;
  logic   carry_c;
  stage_t pipe_d [LATENCY];
  stage_t pipe_q [LATENCY];

  // Stage 0 adder logic and next value of every pipeline stage.
  // Data captures regardless of in_valid; only the valid bit follows in_valid.
  always_comb begin
    sum_c     = A ^ B ^ Cin;
    carry_c   = (A & B) | (A & Cin) | (B & Cin);
    pipe_d[0] = '{valid: in_valid, cout: carry_c, s: sum_c};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Free-running shift pipeline; synchronous reset flushes every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign S         = pipe_q[LATENCY-1].s;
  assign Cout      = pipe_q[LATENCY-1].cout;
  assign out_valid = pipe_q[LATENCY-1].valid;

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at LATENCY 1, 2 and 3.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, cin, in_valid;
  logic s1, c1, v1;
  logic s2, c2, v2;
  logic s3, c3, v3;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Hand-written truth table, {Cout,S} indexed by {A,B,Cin}.
  logic [1:0] tt [8];
  initial begin
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;
  end

  always #5 clk = ~clk;

  full_adder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .S(s1), .Cout(c1), .A(a), .B(b), .Cin(cin),
    .in_valid(in_valid), .out_valid(v1)
  );
  full_adder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .S(s2), .Cout(c2), .A(a), .B(b), .Cin(cin),
    .in_valid(in_valid), .out_valid(v2)
  );
  full_adder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .S(s3), .Cout(c3), .A(a), .B(b), .Cin(cin),
    .in_valid(in_valid), .out_valid(v3)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] abc, input logic v);
    {a, b, cin} = abc;
    in_valid    = v;
  endtask

  task automatic idle(input int unsigned n);
    drive(3'b000, 1'b0);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Ripple a 4-bit add through the LATENCY=1 cell one bit per cycle.
  task automatic ripple(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic c0, input logic [3:0] exp_s, input logic exp_c);
    logic [3:0] sum;
    logic       carry;
    carry = c0;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      drive({av[i], bv[i], carry}, 1'b1);
      tick();
      sum[i] = s1;
      carry  = c1;
    end
    check({tag, "_sum"}, sum, exp_s);
    check({tag, "_cout"}, {3'b000, carry}, {3'b000, exp_c});
  endtask

  initial begin
    // Reset held with all inputs high: nothing gets through.
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_l1", {1'b0, v1, c1, s1}, 4'h0);
      check("rst_l2", {1'b0, v2, c2, s2}, 4'h0);
      check("rst_l3", {1'b0, v3, c3, s3}, 4'h0);
    end
    rst_n = 1'b1;
    #3;
    check("rel_l1", {1'b0, v1, c1, s1}, 4'h0);
    check("rel_l3", {1'b0, v3, c3, s3}, 4'h0);
    idle(4);

    // Exhaustive truth table, back-to-back; L3 trails by two edges.
    for (int v = 0; v < 8; v++) begin
      drive(3'(v), 1'b1);
      tick();
      check($sformatf("tt_l1_%0d", v), {1'b0, v1, c1, s1}, {2'b01, tt[v]});
      if (v >= 2)
        check($sformatf("tt_l3_%0d", v - 2), {1'b0, v3, c3, s3}, {2'b01, tt[v-2]});
    end
    idle(4);
    check("idle_l1", {3'b000, v1}, 4'h0);

    // Ripple use of one cell.
    ripple("add_1_5", 4'b0001, 4'b0101, 1'b0, 4'b0110, 1'b0);
    ripple("sub_5_5", 4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1);
    ripple("add_3_3", 4'b0011, 4'b0011, 1'b0, 4'b0110, 1'b0);
    idle(4);

    // Single pulse through LATENCY=3: visible only after the third edge.
    drive(3'b101, 1'b1);
    tick();
    check("lat3_t0", {1'b0, v3, c3, s3}, 4'h0);
    drive(3'b000, 1'b0);
    for (int t = 1; t < 6; t++) begin
      tick();
      check($sformatf("lat3_t%0d", t), {1'b0, v3, c3, s3}, (t == 2) ? 4'b0110 : 4'h0);
    end
    idle(3);

    // Alternating valid with changing operands; data captures even when invalid.
    begin
      logic [2:0] prev;
      logic       prev_v;
      prev = '0;
      prev_v = 1'b0;
      for (int j = 0; j < 8; j++) begin
        logic [2:0] vec;
        logic       pv;
        vec = 3'((j * 3 + 1) % 8);
        pv  = (j % 2 == 0);
        drive(vec, pv);
        tick();
        check($sformatf("gap_l1_%0d", j), {1'b0, v1, c1, s1}, {1'b0, pv, tt[vec]});
        if (j >= 1)
          check($sformatf("gap_l2_%0d", j), {1'b0, v2, c2, s2}, {1'b0, prev_v, tt[prev]});
        prev   = vec;
        prev_v = pv;
      end
    end
    idle(4);

    // Two results in flight in L3, flushed by a one-edge reset.
    drive(3'b110, 1'b1);
    tick();
    drive(3'b111, 1'b1);
    tick();
    check("mid_l3_pre", {3'b000, v3}, 4'h0);
    rst_n = 1'b0;
    drive(3'b000, 1'b0);
    tick();
    rst_n = 1'b1;
    check("mid_l3_rst", {1'b0, v3, c3, s3}, 4'h0);
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("mid_l3_%0d", t), {1'b0, v3, c3, s3}, 4'h0);
    end

    // L2: one in flight, reset edge also presents a discarded input.
    drive(3'b110, 1'b1);
    tick();
    check("mid_l2_pre", {3'b000, v2}, 4'h0);
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(3'b000, 1'b0);
    check("mid_l2_rst", {1'b0, v2, c2, s2}, 4'h0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("mid_l2_%0d", t), {1'b0, v2, c2, s2}, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
